// File: rtl/alu_ops_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_ops_pkg                                                                |
// | Shared ALU Operation codes, ALUOp encodings and Funct7 constants.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_ops_pkg;

    localparam logic [3:0] c_op_and     = 4'b0000;
    localparam logic [3:0] c_op_or      = 4'b0001;
    localparam logic [3:0] c_op_add     = 4'b0010;
    localparam logic [3:0] c_op_sll     = 4'b0100;
    localparam logic [3:0] c_op_srl     = 4'b0101;
    localparam logic [3:0] c_op_sub     = 4'b0110;
    localparam logic [3:0] c_op_sra     = 4'b0111;
    localparam logic [3:0] c_op_eq      = 4'b1000;
    localparam logic [3:0] c_op_xor     = 4'b1001;
    localparam logic [3:0] c_op_lt      = 4'b1100;
    localparam logic [3:0] c_op_ne      = 4'b1110;
    localparam logic [3:0] c_op_illegal = 4'b1111;

    typedef enum logic [1:0] {
        ALUOP_LDST   = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    localparam logic [6:0] c_f7_base = 7'h00;
    localparam logic [6:0] c_f7_alt  = 7'h20;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_decode                                                              |
// | Combinational ALUOp/Funct3/Funct7 -> Operation, illegal flag, shamt select.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_op_decode
    import alu_ops_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] Funct3,
    input  logic [6:0] Funct7,
    output logic [3:0] Operation,
    output logic       decode_illegal,
    output logic       shamt_sel
);

    logic w_rtype;
    logic w_f7_base;
    logic w_f7_alt;
    logic w_f7_ok;

    assign w_rtype   = (aluop_e'(ALUOp) == ALUOP_RTYPE);
    assign w_f7_base = (Funct7 == c_f7_base);
    assign w_f7_alt  = (Funct7 == c_f7_alt);
    // I-type Funct7 bits belong to the immediate, so only R-type checks them
    assign w_f7_ok   = !w_rtype || w_f7_base;

    always_comb begin
        Operation = c_op_illegal;
        case (aluop_e'(ALUOp))
            ALUOP_LDST: Operation = c_op_add;
            ALUOP_BRANCH: begin
                case (Funct3)
                    3'b000:  Operation = c_op_eq;
                    3'b001:  Operation = c_op_ne;
                    3'b100:  Operation = c_op_lt;
                    default: Operation = c_op_illegal;
                endcase
            end
            default: begin
                case (Funct3)
                    3'b000: begin
                        if (!w_rtype || w_f7_base) Operation = c_op_add;
                        else if (w_f7_alt)         Operation = c_op_sub;
                    end
                    3'b001: if (w_f7_base) Operation = c_op_sll;
                    3'b010: if (w_f7_ok)   Operation = c_op_lt;
                    3'b100: if (w_f7_ok)   Operation = c_op_xor;
                    3'b101: begin
                        if (w_f7_base)     Operation = c_op_srl;
                        else if (w_f7_alt) Operation = c_op_sra;
                    end
                    3'b110: if (w_f7_ok)   Operation = c_op_or;
                    3'b111: if (w_f7_ok)   Operation = c_op_and;
                    default: Operation = c_op_illegal;
                endcase
            end
        endcase
    end

    assign decode_illegal = (Operation == c_op_illegal);
    assign shamt_sel      = (aluop_e'(ALUOp) == ALUOP_ITYPE) &&
                            ((Funct3 == 3'b001) || (Funct3 == 3'b101));

endmodule
`default_nettype wire

// File: rtl/alu_op_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_op_issue                                                               |
// | ID/EX issue register: decodes the ALU op, selects operands, counts illegal.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_op_issue
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic [DATA_WIDTH-1:0]    RD1,
    input  logic [DATA_WIDTH-1:0]    RD2,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic                     ALUSrc,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    output logic                     illegal,
    output logic [CNT_WIDTH-1:0]     illegal_cnt
);

    logic [3:0]               w_op;
    logic                     w_illegal;
    logic                     w_shamt_sel;
    logic [DATA_WIDTH-1:0]    w_srcb_next;

    logic [DATA_WIDTH-1:0]    r_srca;
    logic [DATA_WIDTH-1:0]    r_srcb;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic                     r_valid;
    logic                     r_illegal;
    logic [CNT_WIDTH-1:0]     r_cnt;

    alu_op_decode u_decode (
        .ALUOp          (ALUOp),
        .Funct3         (Funct3),
        .Funct7         (Funct7),
        .Operation      (w_op),
        .decode_illegal (w_illegal),
        .shamt_sel      (w_shamt_sel)
    );

    // Immediate shifts carry funct7 in Imm[11:5]; only the shamt reaches the ALU
    assign w_srcb_next = w_shamt_sel ? {{(DATA_WIDTH-5){1'b0}}, Imm[4:0]}
                                     : (ALUSrc ? Imm : RD2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_srca    <= '0;
            r_srcb    <= '0;
            r_op      <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (flush) begin
            r_srca    <= '0;
            r_srcb    <= '0;
            r_op      <= OPCODE_LENGTH'(c_op_add);
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!stall) begin
            r_srca    <= RD1;
            r_srcb    <= w_srcb_next;
            r_op      <= OPCODE_LENGTH'(w_op);
            r_valid   <= in_valid;
            r_illegal <= in_valid && w_illegal;
            if (in_valid && w_illegal && (r_cnt != {CNT_WIDTH{1'b1}}))
                r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign SrcA        = r_srca;
    assign SrcB        = r_srcb;
    assign Operation   = r_op;
    assign out_valid   = r_valid;
    assign illegal     = r_illegal;
    assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_op_issue                                                            |
// | Directed stimulus with a behavioural reference model and per-cycle compare.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush, ALUSrc;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [31:0] RD1, RD2, Imm;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        out_valid, illegal;
    logic [7:0]  illegal_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7), .RD1(RD1), .RD2(RD2),
        .Imm(Imm), .ALUSrc(ALUSrc), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .out_valid(out_valid), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the opcode tables, not from the RTL structure
    function automatic logic [3:0] ref_op(input logic [1:0] aop, input logic [2:0] f3,
                                          input logic [6:0] f7);
        logic [3:0] base;
        logic       alt_ok;
        if (aop == 2'b00) return 4'b0010;
        if (aop == 2'b01)
            return (f3 == 3'd0) ? 4'b1000 : (f3 == 3'd1) ? 4'b1110 :
                   (f3 == 3'd4) ? 4'b1100 : 4'b1111;
        case (f3)
            3'd0: base = 4'b0010;
            3'd1: base = 4'b0100;
            3'd2: base = 4'b1100;
            3'd4: base = 4'b1001;
            3'd5: base = 4'b0101;
            3'd6: base = 4'b0001;
            3'd7: base = 4'b0000;
            default: return 4'b1111;
        endcase
        if (aop == 2'b11 && f3 != 3'd1 && f3 != 3'd5) return base;
        if (f7 == 7'h00) return base;
        alt_ok = (aop == 2'b10 && f3 == 3'd0) || f3 == 3'd5;
        if (f7 == 7'h20 && alt_ok) return (f3 == 3'd0) ? 4'b0110 : 4'b0111;
        return 4'b1111;
    endfunction

    logic [31:0] m_srca, m_srcb;
    logic [3:0]  m_op;
    logic        m_valid, m_ill;
    int          m_cnt;
    bit          m_known = 1'b0;

    always @(posedge clk) begin
        logic [3:0] op;
        if (reset) begin
            m_srca = 0; m_srcb = 0; m_op = 0; m_valid = 0; m_ill = 0; m_cnt = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (flush) begin
                m_srca = 0; m_srcb = 0; m_op = 4'b0010; m_valid = 0; m_ill = 0;
            end else if (!stall) begin
                op      = ref_op(ALUOp, Funct3, Funct7);
                m_srca  = RD1;
                m_srcb  = (ALUOp == 2'b11 && (Funct3 == 3'd1 || Funct3 == 3'd5))
                          ? {27'b0, Imm[4:0]} : (ALUSrc ? Imm : RD2);
                m_op    = op;
                m_valid = in_valid;
                m_ill   = in_valid && (op == 4'b1111);
                if (m_ill && m_cnt < 255) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("cyc_srca",  SrcA, m_srca);
            check("cyc_srcb",  SrcB, m_srcb);
            check("cyc_op",    {28'b0, Operation}, {28'b0, m_op});
            check("cyc_valid", {31'b0, out_valid}, {31'b0, m_valid});
            check("cyc_ill",   {31'b0, illegal}, {31'b0, m_ill});
            check("cyc_cnt",   {24'b0, illegal_cnt}, m_cnt);
        end
    end

    task automatic drive(input logic rst, input logic v, input logic st, input logic fl,
                         input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic src);
        reset = rst; in_valid = v; stall = st; flush = fl;
        ALUOp = aop; Funct3 = f3; Funct7 = f7; RD1 = a; RD2 = b; Imm = im; ALUSrc = src;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset for two cycles
        drive(1, 0, 0, 0, 2'b00, 3'd0, 7'h00, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 2'b10, 3'd3, 7'h00, 32'h55, 32'h66, 0, 0);
        check("rst_op",   {28'b0, Operation}, 32'h0);
        check("rst_srca", SrcA, 32'h0);
        check("rst_valid",{31'b0, out_valid}, 32'h0);
        check("rst_cnt",  {24'b0, illegal_cnt}, 32'h0);

        // stalled after release: nothing moves
        drive(0, 1, 1, 0, 2'b10, 3'd3, 7'h00, 32'h55, 32'h66, 0, 0);
        check("hold_srca", SrcA, 32'h0);
        check("hold_cnt",  {24'b0, illegal_cnt}, 32'h0);

        // R-type SUB
        drive(0, 1, 0, 0, 2'b10, 3'd0, 7'h20, 32'd10, 32'd3, 32'd99, 0);
        check("sub_op",    {28'b0, Operation}, 32'h6);
        check("sub_srca",  SrcA, 32'd10);
        check("sub_srcb",  SrcB, 32'd3);
        check("sub_valid", {31'b0, out_valid}, 32'h1);

        // SRAI: Funct7 equals Imm[11:5]
        drive(0, 1, 0, 0, 2'b11, 3'd5, 7'h20, 32'd7, 32'd8, 32'h0000_0403, 1);
        check("srai_op",   {28'b0, Operation}, 32'h7);
        check("srai_srcb", SrcB, 32'h3);

        // ADDI with a negative immediate ignores Funct7
        drive(0, 1, 0, 0, 2'b11, 3'd0, 7'h7f, 32'd4, 32'd8, 32'hffff_fff0, 1);
        check("addi_op",   {28'b0, Operation}, 32'h2);
        check("addi_srcb", SrcB, 32'hffff_fff0);

        // illegal branch, then three stalled cycles with a different illegal pending
        drive(0, 1, 0, 0, 2'b01, 3'd2, 7'h00, 32'd1, 32'd2, 0, 0);
        check("br_op",  {28'b0, Operation}, 32'hf);
        check("br_ill", {31'b0, illegal}, 32'h1);
        check("br_cnt", {24'b0, illegal_cnt}, 32'h1);
        for (int i = 0; i < 3; i++)
            drive(0, 1, 1, 0, 2'b10, 3'd3, 7'h00, 32'd9, 32'd9, 0, 0);
        check("stall_cnt",  {24'b0, illegal_cnt}, 32'h1);
        check("stall_srca", SrcA, 32'd1);

        // ADD then stall+flush together
        drive(0, 1, 0, 0, 2'b00, 3'd7, 7'h7f, 32'd1, 32'd2, 32'd100, 1);
        check("ld_srcb", SrcB, 32'd100);
        drive(0, 1, 1, 1, 2'b10, 3'd3, 7'h00, 32'd5, 32'd6, 0, 0);
        check("fl_valid", {31'b0, out_valid}, 32'h0);
        check("fl_op",    {28'b0, Operation}, 32'h2);
        check("fl_srca",  SrcA, 32'h0);
        check("fl_cnt",   {24'b0, illegal_cnt}, 32'h1);

        // in_valid=0 with an illegal R-type XOR: fields still load, nothing counted
        drive(0, 0, 0, 0, 2'b10, 3'd4, 7'h01, 32'd11, 32'd12, 0, 0);
        check("nv_op",    {28'b0, Operation}, 32'hf);
        check("nv_ill",   {31'b0, illegal}, 32'h0);
        check("nv_srcb",  SrcB, 32'd12);
        check("nv_cnt",   {24'b0, illegal_cnt}, 32'h1);

        // burst of illegal loads saturates the counter
        for (int i = 0; i < 300; i++)
            drive(0, 1, 0, 0, 2'b10, 3'd3, 7'h00, i, i + 1, 0, 0);
        check("sat_cnt", {24'b0, illegal_cnt}, 32'd255);

        // reset mid-burst clears everything
        drive(1, 1, 0, 0, 2'b10, 3'd3, 7'h00, 32'd1, 32'd1, 0, 0);
        check("mid_rst_cnt",   {24'b0, illegal_cnt}, 32'h0);
        check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        drive(0, 1, 0, 0, 2'b10, 3'd3, 7'h00, 32'd1, 32'd1, 0, 0);
        check("post_rst_cnt",  {24'b0, illegal_cnt}, 32'h1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
